// File: rtl/bus_timeout.sv
// Bus watchdog between the CPU master port and busctrl: forwards transfers,
// aborts any transfer held in wait longer than the programmed limit, and records the fault.
module bus_timeout #(
    parameter int DEFAULT_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic        cpu_wr,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_data_out,
    output logic [31:0] cpu_data_in,
    output logic        cpu_wt,
    output logic        bus_en,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_data_out,
    input  logic [31:0] bus_data_in,
    input  logic        bus_wt,
    input  logic        en,
    input  logic        wr,
    input  logic [1:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        wt,
    output logic        irq
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ABORT = 1'b1;

    logic [0:0]  state;
    logic [15:0] cnt;
    logic [15:0] limit;
    logic        pending;
    logic        ien;
    logic        te;
    logic [31:0] fault_addr;
    logic [2:0]  fault_info;

    logic waiting;
    logic hit_limit;
    logic ctrl_wr;
    logic limit_wr;
    logic unused_bits;

    assign waiting   = cpu_en & bus_wt;
    // Fires on the edge closing the limit-th wait cycle, so the CPU sees exactly limit waits.
    assign hit_limit = (state == IDLE) & waiting & te & (limit != 16'd0)
                     & (cnt == limit - 16'd1);
    assign ctrl_wr   = en & wr & (addr == 2'd0);
    assign limit_wr  = en & wr & (addr == 2'd3);
    assign unused_bits = &{1'b0, data_in[31:16]};

    // Address, size and write data always pass through; only the handshake is overridden.
    assign bus_wr       = cpu_wr;
    assign bus_size     = cpu_size;
    assign bus_addr     = cpu_addr;
    assign bus_data_out = cpu_data_out;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        bus_en      = cpu_en;
        cpu_wt      = bus_wt;
        cpu_data_in = bus_data_in;
        if (state == ABORT) begin
            bus_en      = 1'b0;
            cpu_wt      = 1'b0;
            cpu_data_in = 32'hFFFF_FFFF;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 16'd0;
            fault_addr <= 32'd0;
            fault_info <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit_limit) begin
                        state      <= ABORT;
                        cnt        <= 16'd0;
                        fault_addr <= cpu_addr;
                        fault_info <= {cpu_wr, cpu_size};
                    end else if (waiting) begin
                        if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
                    end else begin
                        cnt <= 16'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 16'd0;
                end
            endcase
        end
    end

    // A fault on the same edge as a write-1-clear leaves pending set.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
            ien     <= 1'b0;
            te      <= 1'b1;
            limit   <= 16'(DEFAULT_LIMIT);
            irq     <= 1'b0;
        end else begin
            if (hit_limit)                   pending <= 1'b1;
            else if (ctrl_wr && data_in[0])  pending <= 1'b0;
            if (ctrl_wr) begin
                ien <= data_in[1];
                te  <= data_in[2];
            end
            if (limit_wr) limit <= data_in[15:0];
            irq <= pending & ien;
        end
    end

    always_comb begin
        data_out = 32'd0;
        case (addr)
            2'd0:    data_out = {29'd0, te, ien, pending};
            2'd1:    data_out = fault_addr;
            2'd2:    data_out = {29'd0, fault_info};
            default: data_out = {16'd0, limit};
        endcase
    end

    assign wt = 1'b0;

endmodule

// File: tb/tb_bus_timeout.sv
// Scoreboard bench for bus_timeout: stimulus queues expected CPU completions and
// register reads, a monitor pops and compares whenever the DUT completes one.
module tb_bus_timeout;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_en, cpu_wr;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_data_out, cpu_data_in;
    logic        cpu_wt;
    logic        bus_en, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_data_out, bus_data_in;
    logic        bus_wt;
    logic        en, wr;
    logic [1:0]  addr;
    logic [31:0] data_in, data_out;
    logic        wt, irq;

    bus_timeout #(.DEFAULT_LIMIT(1024)) dut (
        .clk(clk), .reset(reset),
        .cpu_en(cpu_en), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
        .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in), .cpu_wt(cpu_wt),
        .bus_en(bus_en), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_data_out(bus_data_out), .bus_data_in(bus_data_in), .bus_wt(bus_wt),
        .en(en), .wr(wr), .addr(addr), .data_in(data_in), .data_out(data_out),
        .wt(wt), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          waits;
    } cpu_exp_t;

    cpu_exp_t    q_cpu[$];
    logic [31:0] q_reg[$];
    int n_checks = 0;
    int n_pass   = 0;
    int wait_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // Monitor: a CPU transfer completes on any cycle with cpu_en & !cpu_wt.
    always @(negedge clk) begin
        if (cpu_en) begin
            if (cpu_wt) begin
                wait_cnt++;
            end else begin
                if (q_cpu.size() == 0) begin
                    check("cpu_unexpected_completion", 32'(q_cpu.size()), 32'd1);
                end else begin
                    cpu_exp_t e;
                    e = q_cpu.pop_front();
                    check("cpu_data_in", cpu_data_in, e.data);
                    check("cpu_wait_cycles", 32'(wait_cnt), 32'(e.waits));
                end
                wait_cnt = 0;
            end
        end
        if (en && !wr) begin
            if (q_reg.size() == 0) begin
                check("reg_unexpected_read", 32'(q_reg.size()), 32'd1);
            end else begin
                check($sformatf("reg%0d_read", addr), data_out, q_reg.pop_front());
            end
            check("reg_wt", {31'd0, wt}, 32'd0);
        end
    end

    task automatic reg_wr(input logic [1:0] ra, input logic [31:0] rd);
        en = 1'b1; wr = 1'b1; addr = ra; data_in = rd;
        @(posedge clk); #1;
        en = 1'b0; wr = 1'b0;
    endtask

    task automatic reg_rd(input logic [1:0] ra, input logic [31:0] exp);
        q_reg.push_back(exp);
        en = 1'b1; wr = 1'b0; addr = ra;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    // Drives one CPU transfer; the device holds bus_wt for dev_waits cycles.
    task automatic cpu_xfer(input logic xwr, input logic [1:0] xsize, input logic [31:0] xa,
                            input logic [31:0] xd, input logic [31:0] dev_d, input int dev_waits,
                            input logic [31:0] exp_d, input int exp_waits,
                            output logic be_done, output logic irq_done);
        int  n;
        logic done;
        q_cpu.push_back('{exp_d, exp_waits});
        cpu_en = 1'b1; cpu_wr = xwr; cpu_size = xsize; cpu_addr = xa;
        cpu_data_out = xd; bus_data_in = dev_d;
        n = 0; done = 1'b0; be_done = 1'bx; irq_done = 1'bx;
        while (!done && n < 6000) begin
            bus_wt = (n < dev_waits);
            @(negedge clk);
            if (!cpu_wt) begin
                done = 1'b1;
                be_done = bus_en;
                irq_done = irq;
                check("fwd_addr", bus_addr, xa);
                check("fwd_data_out", bus_data_out, xd);
                check("fwd_wr_size", {29'd0, bus_wr, bus_size}, {29'd0, xwr, xsize});
            end
            @(posedge clk); #1;
            n++;
        end
        check("xfer_completed", {31'd0, done}, 32'd1);
        cpu_en = 1'b0; bus_wt = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic be, iq;
        reset = 1'b1; cpu_en = 1'b0; cpu_wr = 1'b0; cpu_size = 2'd0;
        cpu_addr = 32'h1234_5678; cpu_data_out = 32'd0; bus_data_in = 32'd0; bus_wt = 1'b0;
        en = 1'b0; wr = 1'b0; addr = 2'd0; data_in = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_passthrough_addr", bus_addr, 32'h1234_5678);
        reset = 1'b0;

        // Reset state.
        check("reset_irq", {31'd0, irq}, 32'd0);
        reg_rd(2'd0, 32'h4);
        reg_rd(2'd1, 32'h0);
        reg_rd(2'd2, 32'h0);
        reg_rd(2'd3, 32'd1024);

        // 1. Normal traffic with 0..3 waits.
        cpu_xfer(1'b0, 2'd2, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, be, iq);
        check("normal_bus_en", {31'd0, be}, 32'd1);
        cpu_xfer(1'b1, 2'd2, 32'h0000_0104, 32'hA5A5_5A5A, 32'h1111_2222, 1, 32'h1111_2222, 1, be, iq);
        cpu_xfer(1'b0, 2'd1, 32'h0000_0108, 32'h0,         32'h0BAD_F00D, 2, 32'h0BAD_F00D, 2, be, iq);
        cpu_xfer(1'b1, 2'd0, 32'h0000_010C, 32'h0000_00FF, 32'h7654_3210, 3, 32'h7654_3210, 3, be, iq);
        reg_rd(2'd0, 32'h4);
        check("normal_irq", {31'd0, irq}, 32'd0);

        // 2. Timeout with limit=4 (upper write bits ignored).
        reg_wr(2'd3, 32'hFFFF_0004);
        reg_rd(2'd3, 32'h4);
        reg_wr(2'd0, 32'h6);
        cpu_xfer(1'b0, 2'd2, 32'hF040_0000, 32'h0, 32'h5555_5555, 100, 32'hFFFF_FFFF, 4, be, iq);
        check("abort_bus_en", {31'd0, be}, 32'd0);
        check("abort_irq_not_yet", {31'd0, iq}, 32'd0);
        check("abort_irq_after", {31'd0, irq}, 32'd1);
        reg_rd(2'd1, 32'hF040_0000);
        reg_rd(2'd2, 32'h2);
        reg_rd(2'd0, 32'h7);

        // 3. Boundary: release on wait cycle 4 is normal, on cycle 5 is a fault.
        reg_wr(2'd0, 32'h7);
        reg_rd(2'd0, 32'h6);
        cpu_xfer(1'b0, 2'd2, 32'h0000_0200, 32'h0, 32'h2468_ACE0, 3, 32'h2468_ACE0, 3, be, iq);
        reg_rd(2'd0, 32'h6);
        cpu_xfer(1'b1, 2'd1, 32'h1000_0010, 32'h0000_BEEF, 32'h1357_9BDF, 4, 32'hFFFF_FFFF, 4, be, iq);
        reg_rd(2'd0, 32'h7);
        reg_rd(2'd2, 32'h5);
        reg_rd(2'd1, 32'h1000_0010);

        // 4. Clear race: ctrl write lands on the abort edge; the fault wins.
        fork
            cpu_xfer(1'b0, 2'd0, 32'h2000_0000, 32'h0, 32'h9999_9999, 10, 32'hFFFF_FFFF, 4, be, iq);
            begin
                repeat (3) @(posedge clk);
                #1;
                reg_wr(2'd0, 32'h3);
            end
        join
        reg_rd(2'd0, 32'h3);
        reg_rd(2'd1, 32'h2000_0000);
        check("race_irq_stays", {31'd0, irq}, 32'd1);
        reg_wr(2'd0, 32'h1);
        check("clear_irq_registered", {31'd0, irq}, 32'd1);
        @(posedge clk); #1;
        check("clear_irq_low", {31'd0, irq}, 32'd0);
        reg_rd(2'd0, 32'h0);

        // 5. Disabled: te=0 with a 5000-cycle wait, then limit=0 with te=1.
        cpu_xfer(1'b0, 2'd2, 32'h3000_0000, 32'h0, 32'hCAFE_F00D, 5000, 32'hCAFE_F00D, 5000, be, iq);
        reg_rd(2'd0, 32'h0);
        reg_wr(2'd3, 32'h0);
        reg_wr(2'd0, 32'h4);
        cpu_xfer(1'b1, 2'd2, 32'h3000_0004, 32'h1234_0000, 32'h0F0F_0F0F, 50, 32'h0F0F_0F0F, 50, be, iq);
        reg_rd(2'd0, 32'h4);

        // 6. Reset during wait cycle 5 with limit=8: no abort, registers back to reset values.
        reg_wr(2'd3, 32'h8);
        reg_wr(2'd0, 32'h6);
        fork
            cpu_xfer(1'b0, 2'd2, 32'h4000_0000, 32'h0, 32'hFACE_B00C, 20, 32'hFACE_B00C, 20, be, iq);
            begin
                repeat (4) @(posedge clk);
                #1 reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
            end
        join
        check("reset_mid_bus_en", {31'd0, be}, 32'd1);
        reg_rd(2'd0, 32'h4);
        reg_rd(2'd3, 32'd1024);
        reg_rd(2'd1, 32'h0);

        check("cpu_queue_drained", 32'(q_cpu.size()), 32'd0);
        check("reg_queue_drained", 32'(q_reg.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_timeout.md
Name: bus_timeout

Overview:
Bus watchdog inserted between the CPU bus master port and busctrl. It forwards every transfer unchanged. If the addressed device holds wait for more than a programmable number of cycles, the watchdog terminates the transfer, returns 32'hFFFFFFFF to the CPU and records the fault. It exposes a 4-word register window through busctrl (device slot like tmr) and drives cpu_irq[7].

Parameters:
DEFAULT_LIMIT, 1024, reset value of the 16-bit limit register (max wait cycles).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_en  in  1  CPU bus request
cpu_wr  in  1  CPU write
cpu_size  in  2  CPU transfer size
cpu_addr  in  32  CPU address
cpu_data_out  in  32  write data from CPU
cpu_data_in  out  32  read data to CPU
cpu_wt  out  1  wait to CPU
bus_en  out  1  request to busctrl
bus_wr  out  1  forwarded cpu_wr
bus_size  out  2  forwarded cpu_size
bus_addr  out  32  forwarded cpu_addr
bus_data_out  out  32  forwarded cpu_data_out
bus_data_in  in  32  read data from busctrl
bus_wt  in  1  wait from busctrl
en  in  1  register window select (from busctrl)
wr  in  1  register write
addr  in  2  register index [3:2]
data_in  in  32  register write data
data_out  out  32  register read data
wt  out  1  register wait, constant 0
irq  out  1  fault interrupt, to cpu_irq[7]

Behaviour:
- Clock is clk; reset is synchronous and active-high. Reset values: state IDLE, cnt=0, pending=0, ien=0, te=1, limit=DEFAULT_LIMIT, fault_addr=0, fault_info=0, irq=0. The forwarding outputs are combinational from inputs; with reset=1 they still pass through.
- States: IDLE, ABORT.
- IDLE:
  - Forwarding: bus_en=cpu_en; bus_wr/size/addr/data_out=cpu equivalents; cpu_data_in=bus_data_in; cpu_wt=bus_wt.
  - cnt: cnt <= cnt+1 when cpu_en & bus_wt, else 0. cnt is 16 bits and saturates at 16'hFFFF.
  - Transition to ABORT on the edge where cpu_en & bus_wt & te & limit!=0 & cnt==limit-1. The CPU therefore sees exactly limit cycles of wt=1.
- ABORT (exactly one cycle):
  - bus_en=0; cpu_wt=0; cpu_data_in=32'hFFFFFFFF. This completes the CPU transfer (for writes, the data is dropped).
  - Latched on entry edge: fault_addr<=cpu_addr, fault_info<={wr,size}, pending<=1, cnt<=0.
  - Next state is IDLE. bus_en is low for at least one cycle, so the device sees the request withdrawn.
- te=0 or limit=0: never abort; cnt still counts.
- A transfer that completes on the same edge cnt reaches limit-1 (bus_wt=0) is normal, not a fault.
- Registers, read combinational, wt=0:
  - 0 ctrl/status: bit0 pending (write 1 clears), bit1 ien, bit2 te. Other bits read 0.
  - 1 fault_addr, read-only.
  - 2 fault_info, read-only: bit2 wr, bits1:0 size.
  - 3 limit, bits15:0 r/w, upper bits read 0.
  Writes take effect on the edge of the access cycle.
- Simultaneous events:
  - A fault setting pending and a write-1-clear on the same edge: set wins.
  - A new fault while pending=1 overwrites fault_addr/fault_info.
- A limit write during a pending wait takes effect on the next cnt comparison.
- irq = pending & ien, registered (updates on the edge after pending/ien change).
- Reset asserted mid-wait or in ABORT: next state IDLE, cnt=0, registers to their reset values.

Test Plan:
1. Normal traffic: RAM reads/writes with 0..3 wait cycles → data and wt pass through bit-exact; pending stays 0; irq=0.
2. Timeout: limit=4, te=1, ien=1; read addr 32'hF0400000, bus_wt held 1 → cpu_wt=1 for 4 cycles; cycle 5 cpu_wt=0, bus_en=0, cpu_data_in=32'hFFFFFFFF; then reg1=32'hF0400000, reg2=3'b010, reg0 bit0=1, irq=1 one cycle later.
3. Boundary: limit=4; device releases wt on cycle 4 → normal completion, no fault. Same test with release on cycle 5 → fault.
4. Clear race: write reg0=32'h3 (clear pending, keep ien) on the same edge as a new abort → pending=1, irq stays 1. A later write of 1 alone → pending=0, irq=0 next cycle.
5. Disable: te=0 (or limit=0), device waits 5000 cycles then completes → no abort, transfer completes with device data.
6. Reset mid-wait: limit=8, assert reset at wait cycle 5 → next cycle cnt=0, limit=1024, pending=0, no ABORT cycle occurs.
